// File: rtl/static_port_lookup_pkg.sv
// static_port_lookup_pkg: shared widths, header field positions, register map and FSM states
package static_port_lookup_pkg;
  localparam int UDP_REG_ADDR_WIDTH = 23;
  localparam int CPCI_NF2_DATA_WIDTH = 32;
  localparam logic [7:0] IO_QUEUE_STAGE_NUM = 8'hff;
  localparam int IOQ_SRC_PORT_POS = 16;
  localparam int IOQ_DST_PORT_POS = 0;
  localparam logic [UDP_REG_ADDR_WIDTH-5:0] SPL_BLOCK_TAG = 19'h02A01;
  localparam logic [3:0] SPL_TABLE_BASE = 4'd0;
  localparam logic [3:0] SPL_DROP_CNT = 4'd8;
  typedef enum logic [1:0] {HDR, PAYLOAD, DROP} spl_state_e;
  function automatic logic [31:0] spl_table_rst(input int unsigned i);
    return 32'd1 << (i ^ 1);
  endfunction
endpackage

// File: rtl/static_port_lookup_if.sv
// static_port_lookup_if: packet stream and UDP register ring bundles
interface spl_pkt_if #(parameter int DW = 64, parameter int CW = DW / 8);
  logic [DW-1:0] data;
  logic [CW-1:0] ctrl;
  logic wr;
  logic rdy;
  modport master(output data, ctrl, wr, input rdy);
  modport slave(input data, ctrl, wr, output rdy);
endinterface

interface spl_reg_if import static_port_lookup_pkg::*; #(
  parameter int AW = UDP_REG_ADDR_WIDTH,
  parameter int DW = CPCI_NF2_DATA_WIDTH,
  parameter int SW = 2
);
  logic req;
  logic ack;
  logic rd_wr_L;
  logic [AW-1:0] addr;
  logic [DW-1:0] data;
  logic [SW-1:0] src;
  modport master(output req, ack, rd_wr_L, addr, data, src);
  modport slave(input req, ack, rd_wr_L, addr, data, src);
endinterface

// File: rtl/static_port_lookup_spl_regs.sv
// spl_regs: destination-mask table, drop counter and register-ring slave
module spl_regs import static_port_lookup_pkg::*; #(
  parameter int NUM_OUTPUT_QUEUES = 8,
  parameter logic [UDP_REG_ADDR_WIDTH-5:0] BLOCK_TAG = SPL_BLOCK_TAG
) (
  input  logic clk,
  input  logic reset,
  spl_reg_if.slave reg_i,
  spl_reg_if.master reg_o,
  input  logic [2:0] idx_i,
  output logic [NUM_OUTPUT_QUEUES-1:0] mask_o,
  input  logic drop_inc_i
);
  localparam int NQ = NUM_OUTPUT_QUEUES;
  localparam int DW = CPCI_NF2_DATA_WIDTH;
  logic [NQ-1:0] table_q [8];
  logic [31:0] drop_cnt_q;
  logic [3:0] off, off_rel;
  logic hit, wr_hit, is_tab;
  logic [DW-1:0] rdata;
  assign off = reg_i.addr[3:0];
  assign off_rel = off - SPL_TABLE_BASE;
  assign is_tab = off_rel < 4'd8;
  assign hit = reg_i.req && !reg_i.ack && reg_i.addr[UDP_REG_ADDR_WIDTH-1:4] == BLOCK_TAG;
  assign wr_hit = hit && !reg_i.rd_wr_L;
  assign mask_o = table_q[idx_i];
  // read mux: table entries zero-extended, counter, unmapped offsets read zero
  always_comb rdata = is_tab ? DW'(table_q[off_rel[2:0]]) : off == SPL_DROP_CNT ? DW'(drop_cnt_q) : '0;
  // table writes and drop counting; a counter clear beats a same-cycle increment
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) table_q[i] <= NQ'(spl_table_rst(i));
      drop_cnt_q <= '0;
    end else begin
      if (wr_hit && is_tab) table_q[off_rel[2:0]] <= reg_i.data[NQ-1:0];
      drop_cnt_q <= (wr_hit && off == SPL_DROP_CNT) ? '0 : drop_cnt_q + 32'(drop_inc_i);
    end
  end
  // ring stage: one cycle of delay, ack and read data inserted on a hit
  always_ff @(posedge clk) begin
    if (reset) begin
      reg_o.req <= 1'b0;
      reg_o.ack <= 1'b0;
      reg_o.rd_wr_L <= 1'b0;
      reg_o.addr <= '0;
      reg_o.data <= '0;
      reg_o.src <= '0;
    end else begin
      reg_o.req <= reg_i.req;
      reg_o.ack <= reg_i.ack || hit;
      reg_o.rd_wr_L <= reg_i.rd_wr_L;
      reg_o.addr <= reg_i.addr;
      reg_o.data <= (hit && reg_i.rd_wr_L) ? rdata : reg_i.data;
      reg_o.src <= reg_i.src;
    end
  end
endmodule

// File: rtl/static_port_lookup.sv
// static_port_lookup: rewrites the IOQ destination mask from a per-source table, drops zero-mask packets
module static_port_lookup import static_port_lookup_pkg::*; #(
  parameter int DATA_WIDTH = 64,
  parameter int CTRL_WIDTH = DATA_WIDTH / 8,
  parameter int UDP_REG_SRC_WIDTH = 2,
  parameter int NUM_OUTPUT_QUEUES = 8,
  parameter logic [UDP_REG_ADDR_WIDTH-5:0] BLOCK_TAG = SPL_BLOCK_TAG
) (
  input logic clk,
  input logic reset,
  spl_pkt_if.slave pkt_i,
  spl_pkt_if.master pkt_o,
  spl_reg_if.slave reg_i,
  spl_reg_if.master reg_o
);
  localparam int NQ = NUM_OUTPUT_QUEUES;
  logic [DATA_WIDTH-1:0] mem_data_q [8];
  logic [CTRL_WIDTH-1:0] mem_ctrl_q [8];
  logic [2:0] wr_ptr_q, rd_ptr_q;
  logic [3:0] cnt_q;
  logic wr_en, rd_en, fwd, drop_inc, is_ioq, seen_pl_q, seen_pl_d, out_wr_q;
  logic [DATA_WIDTH-1:0] head_data, dout, out_data_q;
  logic [CTRL_WIDTH-1:0] head_ctrl, out_ctrl_q;
  logic [NQ-1:0] mask;
  spl_state_e fsm_q, fsm_d;
  assign wr_en = pkt_i.wr && cnt_q != 4'd8;
  assign rd_en = cnt_q != 4'd0 && (pkt_o.rdy || fsm_q == DROP);
  assign head_data = mem_data_q[rd_ptr_q];
  assign head_ctrl = mem_ctrl_q[rd_ptr_q];
  assign is_ioq = head_ctrl == CTRL_WIDTH'(IO_QUEUE_STAGE_NUM);
  assign pkt_i.rdy = cnt_q < 4'd7;
  assign pkt_o.wr = out_wr_q;
  assign pkt_o.data = out_data_q;
  assign pkt_o.ctrl = out_ctrl_q;
  spl_regs #(.NUM_OUTPUT_QUEUES(NQ), .BLOCK_TAG(BLOCK_TAG)) u_regs (
    .clk(clk),
    .reset(reset),
    .reg_i(reg_i),
    .reg_o(reg_o),
    .idx_i(head_data[IOQ_SRC_PORT_POS +: 3]),
    .mask_o(mask),
    .drop_inc_i(drop_inc)
  );
  // first-word-fall-through fifo storage; the head is visible without a read cycle
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_data_q[wr_ptr_q] <= pkt_i.data;
      mem_ctrl_q[wr_ptr_q] <= pkt_i.ctrl;
    end
  end
  // fifo pointers and occupancy; reset flushes any partial packet
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_q + 3'(wr_en);
      rd_ptr_q <= rd_ptr_q + 3'(rd_en);
      cnt_q <= cnt_q + 4'(wr_en) - 4'(rd_en);
    end
  end
  // packet FSM state
  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_q <= HDR;
      seen_pl_q <= 1'b0;
    end else begin
      fsm_q <= fsm_d;
      seen_pl_q <= seen_pl_d;
    end
  end
  // per-word decision: forward (rewriting the IOQ mask), drop, or advance packet phase
  always_comb begin
    fsm_d = fsm_q;
    seen_pl_d = seen_pl_q;
    fwd = 1'b0;
    drop_inc = 1'b0;
    dout = head_data;
    if (rd_en) begin
      case (fsm_q)
        HDR: begin
          if (is_ioq && mask == '0) begin
            fsm_d = DROP;
            seen_pl_d = 1'b0;
            drop_inc = 1'b1;
          end else begin
            fwd = 1'b1;
            if (is_ioq) dout[IOQ_DST_PORT_POS +: NQ] = mask;
            if (head_ctrl == '0) fsm_d = PAYLOAD;
          end
        end
        PAYLOAD: begin
          fwd = 1'b1;
          fsm_d = head_ctrl != '0 ? HDR : PAYLOAD;
        end
        DROP: begin
          if (head_ctrl == '0) seen_pl_d = 1'b1;
          else if (seen_pl_q) begin
            fsm_d = HDR;
            seen_pl_d = 1'b0;
          end
        end
        default: fsm_d = HDR;
      endcase
    end
  end
  // single registered output stage
  always_ff @(posedge clk) begin
    if (reset) begin
      out_wr_q <= 1'b0;
      out_data_q <= '0;
      out_ctrl_q <= '0;
    end else begin
      out_wr_q <= fwd;
      if (fwd) begin
        out_data_q <= dout;
        out_ctrl_q <= head_ctrl;
      end
    end
  end
endmodule
